// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: mode encodings,
// the NOP instruction loaded on a flush, and register-field positions.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_RUN    = 3'd0,
        MODE_LDUSE  = 3'd1,
        MODE_DWAIT  = 3'd2,
        MODE_FLUSH  = 3'd3,
        MODE_HALTED = 3'd4
    } mode_e;

    // Instruction word the IF/ID register loads when ifid_flush is set.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Register fields inside a 16-bit instruction: Rs = [10:8], Rt = [7:5].
    localparam int REG_W  = 3;
    localparam int RS_LSB = 8;
    localparam int RT_LSB = 5;

    function automatic logic [REG_W-1:0] instr_rs(input logic [15:0] instr);
        return instr[RS_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] instr_rt(input logic [15:0] instr);
        return instr[RT_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): hazard inputs flow to the controller, enables/flushes and
// status counters flow back.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [hazard_ctrl_pkg::REG_W-1:0] id_rs;
    logic [hazard_ctrl_pkg::REG_W-1:0] id_rt;
    logic                              id_uses_rs;
    logic                              id_uses_rt;
    logic [hazard_ctrl_pkg::REG_W-1:0] ex_dst;
    logic                              ex_regwrite;
    logic                              ex_memtoreg;
    logic                              ex_redirect;
    logic                              imem_stall;
    logic                              dmem_stall;
    logic                              wb_halt;

    logic                              pc_en;
    logic                              ifid_en;
    logic                              ifid_flush;
    logic                              idex_en;
    logic                              idex_valid;
    logic                              exmem_en;
    logic                              memwb_en;
    logic [2:0]                        mode;
    logic [CNT_W-1:0]                  stall_cycles;
    logic [CNT_W-1:0]                  flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dst, ex_regwrite,
               ex_memtoreg, ex_redirect, imem_stall, dmem_stall, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en,
               memwb_en, mode, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dst, ex_regwrite,
               ex_memtoreg, ex_redirect, imem_stall, dmem_stall, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en,
               memwb_en, mode, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: clears on reset, counts when inc_i is high and
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    // Count up on request, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decides per cycle which pipeline registers
// advance, hold, or take a bubble/NOP, tracks a small mode FSM and keeps
// saturating stall-cycle and redirect counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    mode_e            mode_q;
    mode_e            mode_d;
    logic             load_use;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_valid;
    logic             exmem_en;
    logic             memwb_en;
    logic             flush_inc;
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    // Load-use: EX holds a load whose destination a live ID source needs.
    // Register 0 is an ordinary register, so it is compared like any other.
    always_comb begin
        load_use = hz.ex_regwrite & hz.ex_memtoreg &
                   ((hz.id_uses_rs & (hz.id_rs == hz.ex_dst)) |
                    (hz.id_uses_rt & (hz.id_rt == hz.ex_dst)));
    end

    // Priority resolution of enables/flushes and next mode. Outside HALTED
    // the outputs depend only on the inputs; the mode just remembers why we
    // are waiting (FLUSH keeps re-flushing while imem is still stalled).
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_valid = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        flush_inc  = 1'b0;
        mode_d     = MODE_RUN;

        if (rst) begin
            // Run everything so the pipe fills with NOPs/bubbles.
            ifid_flush = 1'b1;
            idex_valid = 1'b0;
        end else if (mode_q == MODE_HALTED) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            idex_valid = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            mode_d     = MODE_HALTED;
        end else begin
            if (hz.dmem_stall) begin
                // Whole pipe frozen; any redirect/hazard stays in place.
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                mode_d   = MODE_DWAIT;
            end else if (hz.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_valid = 1'b0;
                flush_inc  = 1'b1;
                mode_d     = hz.imem_stall ? MODE_FLUSH : MODE_RUN;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_valid = 1'b0;
                mode_d     = MODE_LDUSE;
            end else if (hz.imem_stall) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                mode_d     = (mode_q == MODE_FLUSH) ? MODE_FLUSH : MODE_RUN;
            end
            if (hz.wb_halt) begin
                mode_d = MODE_HALTED;
            end
        end
    end

    // Mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Counter 0 counts stalled fetch cycles, counter 1 accepted redirects.
    // Neither counts in HALTED: the outputs there keep both increments low
    // except for pc_en, which is masked explicitly.
    assign cnt_inc[0] = ~rst & (mode_q != MODE_HALTED) & ~pc_en;
    assign cnt_inc[1] = flush_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .inc_i   (cnt_inc[gi]),
                .count_o (cnt_val[gi])
            );
        end
    endgenerate

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_valid   = idex_valid;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_en     = memwb_en;
    assign hz.mode         = mode_q;
    assign hz.stall_cycles = cnt_val[0];
    assign hz.flush_count  = cnt_val[1];
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control block that produces the stall/enable and bubble/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- ID/EX takes `en` (hold) and `En` (valid; 0 squashes RegWrite/DMemWrite/DMemEn). This block is the driver of those signals.
- Detects load-use hazards, taken-branch/jump redirects, instruction- and data-memory stalls, and halt retirement.
- Keeps a small mode FSM plus saturating performance counters.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_count counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- id_rs  in  3  Rs field of the ID-stage instruction (instr[10:8]).
- id_rt  in  3  Rt field of the ID-stage instruction (instr[7:5]).
- id_uses_rs  in  1  ID instruction reads Rs.
- id_uses_rt  in  1  ID instruction reads Rt.
- ex_dst  in  3  destination register of the EX-stage instruction.
- ex_regwrite  in  1  RegWrite_toex.
- ex_memtoreg  in  1  MemtoReg_toex; EX instruction is a load.
- ex_redirect  in  1  branch/jump resolved taken in EX.
- imem_stall  in  1  instruction memory not ready this cycle.
- dmem_stall  in  1  data memory busy this cycle.
- wb_halt  in  1  HALT instruction reached WB.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  load NOP (16'h0800) into IF/ID.
- idex_en  out  1  ID/EX en.
- idex_valid  out  1  ID/EX En; 0 inserts a bubble.
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- mode  out  3  current FSM state.
- stall_cycles  out  CNT_W  cycles with pc_en=0 outside HALTED.
- flush_count  out  CNT_W  redirect events accepted.

Behaviour:
- States: RUN=0, LDUSE=1, DWAIT=2, FLUSH=3, HALTED=4.
- Enable/flush outputs are combinational from the current state and inputs. State and counters update on posedge clk.
- Reset (rst=1 at posedge):
  - mode=RUN; both counters=0.
  - While rst is high, outputs are: all enables=1, ifid_flush=1, idex_valid=0. The pipe therefore fills with NOPs.
- Priority when not HALTED (highest first):
  1. dmem_stall.
  2. ex_redirect.
  3. Load-use.
  4. imem_stall.
  5. Normal.
- dmem_stall=1: all five enables=0, ifid_flush=0, idex_valid=1. A redirect or hazard in the same cycle is held, not lost, because the pipe is frozen. Next state is DWAIT. The FSM leaves DWAIT to RUN in the first cycle dmem_stall=0, and that cycle evaluates normally.
- ex_redirect:
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_valid=0, exmem_en=memwb_en=1.
  - flush_count increments by 1 (saturating).
  - If imem_stall is also 1, next state is FLUSH. FLUSH holds ifid_flush=1 and pc_en=0 until imem_stall=0, then returns to RUN.
- Load-use condition: ex_regwrite & ex_memtoreg & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
  - Outputs: pc_en=0, ifid_en=0, idex_en=1, idex_valid=0, downstream enables=1.
  - Next state is LDUSE for exactly one cycle, then RUN.
  - The next cycle the EX stage holds the bubble, so the condition deasserts without extra logic.
- imem_stall only: pc_en=0, ifid_en=1, ifid_flush=1; downstream runs normally with idex_valid=1.
- Normal: all enables=1, ifid_flush=0, idex_valid=1.
- wb_halt=1 (any state except reset): next state is HALTED.
  - HALTED is sticky until rst; all enables=0 and idex_valid=0.
  - Counters freeze in HALTED.
- stall_cycles increments (saturating at all-ones) in every non-reset cycle with pc_en=0 and mode!=HALTED.
- Register index 0 is a real register; no special-casing of r0.

Decomposition:
- Shared package:
  - state encodings.
  - NOP instruction constant 16'h0800.
  - Register-field bit positions.
- One natural sub-module, sat_counter (CNT_W wide, inc, rst, saturating), instantiated twice.
- Hazard compare stays inline.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_dst=3, id_rs=3, id_uses_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_valid=0; mode=LDUSE next cycle, then RUN; stall_cycles=1.
- No false stall: same as above but id_uses_rs=0 and id_rt=3, id_uses_rt=0 -> all enables=1, idex_valid=1, stall_cycles stays 0.
- Redirect with imem stall: ex_redirect=1 and imem_stall=1 for 3 cycles -> ifid_flush=1 in all 3 cycles, mode=FLUSH, flush_count=1, then RUN after imem_stall drops.
- Dmem freeze with concurrent redirect: dmem_stall=1 for 4 cycles with ex_redirect=1 -> all enables 0, flush_count unchanged. After the release, the redirect is taken once and flush_count=1.
- Halt: wb_halt pulse -> mode=HALTED, all enables 0 for 10+ cycles, counters frozen. rst=1 -> mode=RUN, counters=0.
- Saturation: CNT_W=4, imem_stall held 20 cycles -> stall_cycles=15 and holds.
